gate_or: RTL and testbench

GATE_OR -- requirements
Module: gate_or

---
 rtl/gate_or_pkg.sv | 9 +
 rtl/gate_or_popcount.sv | 17 +
 rtl/gate_or.sv | 50 +++++
 tb/tb_gate_or.sv | 114 +++++++++++
 4 files changed

// File: rtl/gate_or_pkg.sv
// gate_or_pkg: shared width constant and count-width helper for the gate_or slice
//   DEFAULT_N : default operand/result width
//   cnt_w(n)  : bits needed to hold a population count of 0..n
package gate_or_pkg;
   localparam int DEFAULT_N = 4;
   function automatic int cnt_w(input int n);
      return $clog2(n + 1);
   endfunction
endpackage

// File: rtl/gate_or_popcount.sv
// gate_or_popcount: combinational count of set bits
//   d   : N-bit input vector
//   cnt : number of ones in d, range 0..N
module gate_or_popcount
   import gate_or_pkg::*;
#(
   parameter int N = DEFAULT_N
) (
   input  logic [N-1:0]          d,
   output logic [cnt_w(N)-1:0]   cnt
);
   localparam int CW = cnt_w(N);
   always_comb begin
      cnt = '0;
      for (int i = 0; i < N; i++) cnt = cnt + CW'(d[i]);
   end
endmodule

// File: rtl/gate_or.sv
// gate_or: bitwise OR with a combinational output and a registered result plus flags
//   clk       : clock, rising edge
//   rst_n     : synchronous active-low reset
//   A, B      : N-bit operands
//   in_valid  : qualifies A/B for capture
//   F         : combinational A | B
//   F_q       : registered A | B
//   out_valid : F_q was captured on the previous edge
//   all_ones  : registered flag, F_q all ones
//   all_zero  : registered flag, F_q all zero
//   ones_cnt  : registered set-bit count of F_q
module gate_or
   import gate_or_pkg::*;
#(
   parameter int N = DEFAULT_N
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [N-1:0]          A,
   input  logic [N-1:0]          B,
   input  logic                  in_valid,
   output logic [N-1:0]          F,
   output logic [N-1:0]          F_q,
   output logic                  out_valid,
   output logic                  all_ones,
   output logic                  all_zero,
   output logic [cnt_w(N)-1:0]   ones_cnt
);
   logic [cnt_w(N)-1:0] cnt;
   assign F = A | B;
   gate_or_popcount #(.N(N)) u_popcount (.d(F), .cnt(cnt));
   // Flags are derived from the same OR value as F_q so they always describe it
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         F_q       <= '0;
         out_valid <= 1'b0;
         all_ones  <= 1'b0;
         all_zero  <= 1'b1;
         ones_cnt  <= '0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            F_q      <= F;
            all_ones <= &F;
            all_zero <= ~|F;
            ones_cnt <= cnt;
         end
      end
   end
endmodule

// File: tb/tb_gate_or.sv
// tb_gate_or: table-driven and sweep checks of gate_or with a registered-output scoreboard
module tb_gate_or;
   import gate_or_pkg::*;
   localparam int N  = 4;
   localparam int CW = cnt_w(N);
   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic [N-1:0]  A = '0;
   logic [N-1:0]  B = '0;
   logic [N-1:0]  F, F_q;
   logic          out_valid, all_ones, all_zero;
   logic [CW-1:0] ones_cnt;
   always #5 clk = ~clk;
   gate_or #(.N(N)) dut (
      .clk(clk), .rst_n(rst_n), .A(A), .B(B), .in_valid(in_valid),
      .F(F), .F_q(F_q), .out_valid(out_valid), .all_ones(all_ones),
      .all_zero(all_zero), .ones_cnt(ones_cnt)
   );
   typedef struct packed {
      logic [N-1:0]  fq;
      logic          ov;
      logic          ao;
      logic          az;
      logic [CW-1:0] cnt;
   } reg_t;
   typedef struct {
      logic         r;
      logic         v;
      logic [N-1:0] a;
      logic [N-1:0] b;
      logic [N-1:0] f;
      reg_t         q;
   } vec_t;
   reg_t sb[$];
   int checks = 0;
   int errors = 0;
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   function automatic vec_t mk(input logic r, input logic v, input logic [N-1:0] a,
                               input logic [N-1:0] b, input logic [N-1:0] f,
                               input logic [N-1:0] fq, input logic ov, input logic ao,
                               input logic az, input int cnt);
      vec_t x;
      x.r = r; x.v = v; x.a = a; x.b = b; x.f = f;
      x.q.fq = fq; x.q.ov = ov; x.q.ao = ao; x.q.az = az; x.q.cnt = CW'(cnt);
      return x;
   endfunction
   // Drive one cycle of stimulus: F is checked right away, registered outputs after the edge
   task automatic step(input logic r, input logic v, input logic [N-1:0] a,
                       input logic [N-1:0] b, input logic [N-1:0] f, input reg_t q);
      reg_t e;
      rst_n = r; in_valid = v; A = a; B = b;
      #1;
      chk("F", F, f);
      sb.push_back(q);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         chk("sb_empty", 1, 0);
      end else begin
         e = sb.pop_front();
         chk("F_q", F_q, e.fq);
         chk("out_valid", out_valid, e.ov);
         chk("all_ones", all_ones, e.ao);
         chk("all_zero", all_zero, e.az);
         chk("ones_cnt", ones_cnt, e.cnt);
         chk("flags_excl", all_ones & all_zero, 0);
      end
      @(negedge clk);
   endtask
   vec_t vecs[15];
   reg_t m;
   logic [N-1:0] o;
   logic v;
   initial begin
      vecs[0]  = mk(0, 1, 4'b0011, 4'b0100, 4'b0111, 4'b0000, 0, 0, 1, 0);
      vecs[1]  = mk(0, 1, 4'b0011, 4'b0100, 4'b0111, 4'b0000, 0, 0, 1, 0);
      vecs[2]  = mk(1, 1, 4'b1010, 4'b0101, 4'b1111, 4'b1111, 1, 1, 0, 4);
      vecs[3]  = mk(1, 1, 4'b1100, 4'b1111, 4'b1111, 4'b1111, 1, 1, 0, 4);
      vecs[4]  = mk(1, 1, 4'b0000, 4'b1111, 4'b1111, 4'b1111, 1, 1, 0, 4);
      vecs[5]  = mk(1, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1, 0, 1, 0);
      vecs[6]  = mk(1, 1, 4'b0001, 4'b0010, 4'b0011, 4'b0011, 1, 0, 0, 2);
      vecs[7]  = mk(1, 0, 4'b1111, 4'b1111, 4'b1111, 4'b0011, 0, 0, 0, 2);
      vecs[8]  = mk(1, 0, 4'b0100, 4'b0000, 4'b0100, 4'b0011, 0, 0, 0, 2);
      vecs[9]  = mk(1, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0011, 0, 0, 0, 2);
      vecs[10] = mk(1, 1, 4'b1000, 4'b0000, 4'b1000, 4'b1000, 1, 0, 0, 1);
      vecs[11] = mk(1, 1, 4'b0110, 4'b0001, 4'b0111, 4'b0111, 1, 0, 0, 3);
      vecs[12] = mk(0, 1, 4'b1111, 4'b0000, 4'b1111, 4'b0000, 0, 0, 1, 0);
      vecs[13] = mk(1, 0, 4'b0101, 4'b0000, 4'b0101, 4'b0000, 0, 0, 1, 0);
      vecs[14] = mk(1, 1, 4'b0101, 4'b0000, 4'b0101, 4'b0101, 1, 0, 0, 2);
      @(negedge clk);
      foreach (vecs[i]) step(vecs[i].r, vecs[i].v, vecs[i].a, vecs[i].b, vecs[i].f, vecs[i].q);
      m = vecs[14].q;
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            o = N'(a) | N'(b);
            v = $urandom_range(0, 3) != 0;
            if (v) begin
               m.fq = o; m.ov = 1'b1; m.ao = (o == 4'b1111); m.az = (o == 4'b0000);
               m.cnt = CW'($countones(o));
            end else m.ov = 1'b0;
            step(1'b1, v, N'(a), N'(b), o, m);
         end
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
